// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential multiplier between two requesters.
// Optional BUSY watchdog enabled by defining MUL_SHARE_ARB_TIMEOUT_EN.
module mul_share_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rsp_valid0,
    output logic             rsp_valid1,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] mul_result,
    input  logic             mul_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t state;
    logic   owner;
    logic   last;
    logic   win;

    // Tie goes to whoever was not served last; a lone requester always wins.
    always_comb win = (req0 && req1) ? ~last : req1;

`ifdef MUL_SHARE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          expired;

    assign expired = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                cnt <= '0;
        else if (state != BUSY)  cnt <= '0;
        else                     cnt <= cnt + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last       <= 1'b1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            mul_start  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
        end else begin
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            mul_start  <= 1'b0;
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            case (state)
                IDLE: if (req0 || req1) begin
                    owner     <= win;
                    mul_a     <= win ? a1 : a0;
                    mul_b     <= win ? b1 : b0;
                    gnt0      <= ~win;
                    gnt1      <= win;
                    mul_start <= 1'b1;
                    busy      <= 1'b1;
                    state     <= ISSUE;
                end
                // A done left high by the previous op is never looked at here.
                ISSUE: state <= BUSY;
                BUSY: if (mul_done) begin
                    rsp_data   <= mul_result;
                    rsp_err    <= 1'b0;
                    rsp_valid0 <= ~owner;
                    rsp_valid1 <= owner;
                    state      <= RESP;
                end
`ifdef MUL_SHARE_ARB_TIMEOUT_EN
                else if (expired) begin
                    rsp_data   <= '0;
                    rsp_err    <= 1'b1;
                    rsp_valid0 <= ~owner;
                    rsp_valid1 <= owner;
                    state      <= RESP;
                end
`endif
                RESP: begin
                    last  <= owner;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
